// File: rtl/latency_meter_pkg.sv
// latency_meter_pkg: shared state encoding and default parameters for latency_meter
package latency_meter_pkg;
  typedef enum logic [2:0] {IDLE, ARM, FLASH, RELEASE, HOLDOFF} state_t;
  localparam int unsigned DEFAULT_TIMEOUT = 100_000_000;
  localparam int unsigned DEFAULT_HOLDOFF = 4;
endpackage

// File: rtl/latency_meter.sv
// latency_meter: flashes the screen at a frame boundary and counts clk cycles until the light sensor fires
module latency_meter
  import latency_meter_pkg::*;
#(
  parameter int unsigned COUNT_WIDTH    = 32,
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT,
  parameter int unsigned HOLDOFF_FRAMES = DEFAULT_HOLDOFF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   frame_start,
  input  logic                   light_on,
  output logic                   flash,
  output logic                   busy,
  output logic [COUNT_WIDTH-1:0] result,
  output logic                   result_valid,
  output logic                   timed_out
);
  localparam logic [COUNT_WIDTH-1:0] LAST = COUNT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam int unsigned HF = (HOLDOFF_FRAMES == 0) ? 1 : HOLDOFF_FRAMES;
  state_t state_q, state_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d, result_q, result_d;
  logic [31:0] fcnt_q, fcnt_d;
  logic rv_d, to_d, rv_q, to_q, flash_q, busy_q;
  always_comb begin
    state_d  = state_q;
    cnt_d    = (cnt_q == '1) ? cnt_q : cnt_q + COUNT_WIDTH'(1);
    fcnt_d   = fcnt_q;
    result_d = result_q;
    rv_d     = 1'b0;
    to_d     = 1'b0;
    unique case (state_q)
      IDLE: state_d = ARM;
      ARM: if (frame_start && !light_on) begin
        state_d = FLASH;
        cnt_d   = '0;
      end
      FLASH: if (light_on) begin
        result_d = cnt_q;
        rv_d     = 1'b1;
        state_d  = RELEASE;
        cnt_d    = '0;
      end else if (cnt_q == LAST) begin
        to_d    = 1'b1;
        state_d = RELEASE;
        cnt_d   = '0;
      end
      RELEASE: if (!light_on || cnt_q == LAST) begin
        to_d    = light_on;
        state_d = HOLDOFF;
        fcnt_d  = '0;
      end
      HOLDOFF: if (frame_start) begin
        state_d = (fcnt_q == 32'(HF - 1)) ? ARM : HOLDOFF;
        fcnt_d  = fcnt_q + 32'd1;
      end
      default: state_d = IDLE;
    endcase
    // disabling overrides every transition and suppresses the pulses of this cycle
    if (!enable) begin
      state_d  = IDLE;
      cnt_d    = '0;
      fcnt_d   = '0;
      result_d = result_q;
      rv_d     = 1'b0;
      to_d     = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      fcnt_q   <= '0;
      result_q <= '0;
      rv_q     <= 1'b0;
      to_q     <= 1'b0;
      flash_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      fcnt_q   <= fcnt_d;
      result_q <= result_d;
      rv_q     <= rv_d;
      to_q     <= to_d;
      flash_q  <= state_d == FLASH;
      busy_q   <= state_d != IDLE;
    end
  end
  assign flash        = flash_q;
  assign busy         = busy_q;
  assign result       = result_q;
  assign result_valid = rv_q;
  assign timed_out    = to_q;
endmodule

// File: tb/tb_latency_meter.sv
// tb_latency_meter: directed and randomized checks of latency_meter against a timestamp-based model
module tb_latency_meter;
  localparam int TO = 1000;
  localparam int HOLD = 2;
  localparam int P_IDLE = 0, P_ARM = 1, P_FLASH = 2, P_REL = 3, P_HOLD = 4;
  logic clk = 0, reset = 1, enable = 0, frame_start = 0, light_on = 0;
  logic flash, busy, result_valid, timed_out;
  logic [31:0] result;
  int tests = 0, fails = 0;
  int fphase = 0, fs_total = 0;
  int ph = P_IDLE, t_in = 0, nfr = 0, edge_n = 0;
  logic m_flash = 0, m_busy = 0, m_rv = 0, m_to = 0, mv = 0;
  logic [31:0] m_res = 0;

  latency_meter #(.COUNT_WIDTH(32), .TIMEOUT_CYCLES(TO), .HOLDOFF_FRAMES(HOLD)) dut (
    .clk(clk), .reset(reset), .enable(enable), .frame_start(frame_start), .light_on(light_on),
    .flash(flash), .busy(busy), .result(result), .result_valid(result_valid), .timed_out(timed_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // frame_start: one-cycle pulse every 200 cycles
  always @(negedge clk) begin
    frame_start = (fphase == 199);
    fphase = (fphase == 199) ? 0 : fphase + 1;
    if (frame_start) fs_total++;
  end

  // model: the latency is the edge distance from entering a phase, not a counter register
  always @(posedge clk) begin
    int k;
    edge_n++;
    k = edge_n - t_in - 1;
    m_rv = 0;
    m_to = 0;
    if (reset) begin
      ph = P_IDLE;
      m_res = 0;
    end else if (!enable) ph = P_IDLE;
    else if (ph == P_IDLE) ph = P_ARM;
    else if (ph == P_ARM) begin
      if (frame_start && !light_on) begin ph = P_FLASH; t_in = edge_n; end
    end else if (ph == P_FLASH) begin
      if (light_on) begin m_res = k; m_rv = 1; ph = P_REL; t_in = edge_n; end
      else if (k == TO - 1) begin m_to = 1; ph = P_REL; t_in = edge_n; end
    end else if (ph == P_REL) begin
      if (!light_on) begin ph = P_HOLD; nfr = 0; end
      else if (k == TO - 1) begin m_to = 1; ph = P_HOLD; nfr = 0; end
    end else if (frame_start) begin
      nfr++;
      if (nfr == HOLD) ph = P_ARM;
    end
    m_flash = (ph == P_FLASH);
    m_busy = (ph != P_IDLE);
    mv = 1;
  end

  always @(negedge clk) if (mv) begin
    chk("flash", flash, m_flash);
    chk("busy", busy, m_busy);
    chk("result", result, m_res);
    chk("result_valid", result_valid, m_rv);
    chk("timed_out", timed_out, m_to);
  end

  task automatic step;
    @(negedge clk);
    #1;
  endtask

  task automatic wait_flash;
    int n = 0;
    while (flash !== 1'b1 && n < 2000) begin step; n++; end
    tests++;
    if (flash !== 1'b1) begin
      fails++;
      $display("FAIL wait_flash: flash=%0d after %0d cycles, expected 1", flash, n);
    end
  endtask

  task automatic measure(input int lat);
    wait_flash;
    repeat (lat) step;
    light_on = 1;
    step;
    chk("lit_rv", result_valid, 1);
    chk("lit_result", result, lat);
    chk("lit_flash_drop", flash, 0);
  endtask

  initial begin
    int fs0, nfl, lat, hold;
    bit abort;
    repeat (3) step;
    chk("rst_flash", flash, 0);
    chk("rst_busy", busy, 0);
    chk("rst_result", result, 0);
    chk("rst_rv", result_valid, 0);
    reset = 0;
    enable = 1;
    measure(37);
    chk("model_res", m_res, 37);
    repeat (20) step;
    light_on = 0;
    fs0 = fs_total;
    wait_flash;
    chk("holdoff_frames", fs_total - fs0, 3);
    repeat (999) step;
    chk("to_early", timed_out, 0);
    step;
    chk("to_pulse", timed_out, 1);
    chk("to_result_kept", result, 37);
    chk("to_flash", flash, 0);
    step;
    chk("to_one_cycle", timed_out, 0);
    repeat (5) step;
    light_on = 1;
    fs0 = fs_total;
    nfl = 0;
    while (fs_total - fs0 < 4 && nfl < 100) begin step; nfl += int'(flash); end
    step;
    nfl += int'(flash);
    chk("stale_no_flash", nfl, 0);
    light_on = 0;
    fs0 = fs_total;
    wait_flash;
    chk("stale_next_frame", fs_total - fs0, 1);
    repeat (10) step;
    enable = 0;
    step;
    chk("abort_flash", flash, 0);
    chk("abort_busy", busy, 0);
    chk("abort_rv", result_valid, 0);
    chk("abort_to", timed_out, 0);
    repeat (3) step;
    enable = 1;
    measure(37);
    repeat (5) step;
    reset = 1;
    step;
    chk("mid_rst_result", result, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_flash", flash, 0);
    reset = 0;
    light_on = 0;
    measure(37);
    repeat (3) step;
    light_on = 0;
    for (int n = 0; n < 16; n++) begin
      wait_flash;
      lat = $urandom_range(0, 1100);
      abort = ($urandom_range(0, 5) == 0);
      for (int i = 0; i < lat; i++) begin
        step;
        if (abort && i == lat / 2) begin
          enable = 0;
          step;
          step;
          enable = 1;
        end
      end
      light_on = 1;
      hold = $urandom_range(1, 1200);
      repeat (hold) step;
      light_on = 0;
    end
    repeat (5) step;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
